// File: rtl/pattern_seq_detector_pkg.sv
// Shared constants for the serial pattern detector.
// Default geometry and overlap-mode encodings.
package pattern_det_pkg;

   localparam int         DEF_PAT_LEN = 3;
   localparam logic [2:0] DEF_PATTERN = 3'b111;
   localparam int         DEF_CNT_W   = 8;

   localparam bit OVL_OFF = 1'b0;
   localparam bit OVL_ON  = 1'b1;

endpackage

// File: rtl/pattern_seq_detector_if.sv
// Stream, config and status bundle of the detector.
// master drives the stream; slave is the detector.
interface pattern_seq_detector_if #(
   parameter int PAT_LEN = 3,
   parameter int CNT_W   = 8
);

   logic               en;
   logic               din;
   logic               clr;
   logic               cfg_load;
   logic [PAT_LEN-1:0] cfg_pattern;
   logic               cfg_overlap;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;

   modport master (
      output en, din, clr, cfg_load,
      output cfg_pattern, cfg_overlap,
      input  match, match_cnt, cnt_sat
   );

   modport slave (
      input  en, din, clr, cfg_load,
      input  cfg_pattern, cfg_overlap,
      output match, match_cnt, cnt_sat
   );

endinterface

// File: rtl/pattern_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// sat flags the all-ones value; clr wins over inc.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q;

   // count up on inc, stick at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (inc && !(&cnt_q))
         cnt_q <= cnt_q + 1'b1;
   end

   assign cnt = cnt_q;
   assign sat = &cnt_q;

endmodule

// File: rtl/pattern_seq_detector.sv
// Configurable serial bit-pattern detector.
// Registered match pulse plus saturating match count.
module pattern_seq_detector
   import pattern_det_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
   parameter bit                 OVERLAP = OVL_OFF,
   parameter int                 CNT_W   = DEF_CNT_W
) (
   input logic                    clk,
   input logic                    rst_n,
   pattern_seq_detector_if.slave  bus
);

   localparam int FW = $clog2(PAT_LEN + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

   logic [PAT_LEN-1:0] pat_q;
   logic               ovl_q;
   logic [PAT_LEN-1:0] hist;
   logic [FW-1:0]      fill;
   logic               match_q;

   logic [PAT_LEN-1:0] nh;
   logic [FW-1:0]      nf;
   logic               flush;
   logic               hit;
   logic [CNT_W-1:0]   cnt;
   logic               sat;

   // candidate history/fill and hit detection for an accepted bit
   always_comb begin
      nh    = {hist[PAT_LEN-2:0], bus.din};
      nf    = (fill == FULL) ? fill : fill + 1'b1;
      flush = bus.clr || bus.cfg_load;
      hit   = bus.en && !flush && (nf == FULL) && (nh == pat_q);
   end

   // pattern and overlap configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q <= PATTERN;
         ovl_q <= OVERLAP;
      end else if (bus.cfg_load) begin
         pat_q <= bus.cfg_pattern;
         ovl_q <= bus.cfg_overlap;
      end
   end

   // shift history, fill level and registered match pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist    <= '0;
         fill    <= '0;
         match_q <= 1'b0;
      end else if (flush) begin
         hist    <= '0;
         fill    <= '0;
         match_q <= 1'b0;
      end else if (bus.en) begin
         hist    <= nh;
         fill    <= (hit && ovl_q == OVL_OFF) ? '0 : nf;
         match_q <= hit;
      end else begin
         match_q <= 1'b0;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit),
      .clr   (bus.clr),
      .cnt   (cnt),
      .sat   (sat)
   );

   assign bus.match     = match_q;
   assign bus.match_cnt = cnt;
   assign bus.cnt_sat   = sat;

endmodule
